axi4_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares one axi4_full_wr single-beat write master between NUM_REQ requesters.
- Each requester presents an address/data pair with a valid/ready handshake.
- The arbiter captures the winning pair into holding registers and drives the master's user interface (wr_addr, wr_data, wr_valid, wr_ready).
- It holds wr_valid until the master's one-cycle wr_ready completion pulse, then re-arbitrates.

---
 rtl/axi4_wr_arbiter.sv | 124 ++++++++++++
 tb/tb_axi4_wr_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_wr_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI4 write master between NUM_REQ requesters.
// The winning address/data pair is captured and held until the master's completion pulse.
module axi4_wr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                  m_aclk,
   input  logic                  m_arst_n,
   input  logic [NUM_REQ*32-1:0] req_addr,
   input  logic [NUM_REQ*32-1:0] req_data,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [31:0]           wr_addr,
   output logic [31:0]           wr_data,
   output logic                  wr_valid,
   input  logic                  wr_ready,
   output logic [ID_W-1:0]       grant_id,
   output logic                  busy,
   output logic [CNT_W-1:0]      done_cnt
);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e               state_q, state_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;
   logic [ID_W-1:0]      grant_q, grant_d;
   logic [31:0]          addr_q, addr_d;
   logic [31:0]          data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 busy_q, busy_d;
   logic [NUM_REQ-1:0]   ready_q, ready_d;
   logic [CNT_W-1:0]     done_cnt_q, done_cnt_d;

   logic                 found;
   logic [ID_W-1:0]      winner;
   logic [ID_W-1:0]      idx;

   // Search ptr, ptr+1, ... wrapping modulo NUM_REQ; first set bit wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = ID_W'((32'(ptr_q) + k) % NUM_REQ);
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_d    = grant_q;
      addr_d     = addr_q;
      data_d     = data_q;
      valid_d    = valid_q;
      busy_d     = busy_q;
      ready_d    = '0;
      done_cnt_d = done_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               addr_d  = req_addr[{winner, 5'd0} +: 32];
               data_d  = req_data[{winner, 5'd0} +: 32];
               grant_d = winner;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               ready_d = NUM_REQ'(1) << winner;
               if (32'(winner) + 1 == NUM_REQ) begin
                  ptr_d = '0;
               end else begin
                  ptr_d = winner + 1'b1;
               end
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (wr_ready) begin
               valid_d    = 1'b0;
               busy_d     = 1'b0;
               done_cnt_d = done_cnt_q + 1'b1;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge m_aclk or negedge m_arst_n) begin
      if (!m_arst_n) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         grant_q    <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= '0;
         done_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
         done_cnt_q <= done_cnt_d;
      end
   end

   assign wr_addr   = addr_q;
   assign wr_data   = data_q;
   assign wr_valid  = valid_q;
   assign busy      = busy_q;
   assign req_ready = ready_q;
   assign grant_id  = grant_q;
   assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// Self-checking bench for axi4_wr_arbiter: table of grant vectors plus reset, spurious
// completion and counter-wrap sequences, with a scoreboard of expected captured writes.
module tb_axi4_wr_arbiter;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned ID_W    = 2;
   localparam int unsigned CNT_W   = 16;

   logic                  m_aclk;
   logic                  m_arst_n;
   logic [NUM_REQ*32-1:0] req_addr;
   logic [NUM_REQ*32-1:0] req_data;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [31:0]           wr_addr;
   logic [31:0]           wr_data;
   logic                  wr_valid;
   logic                  wr_ready;
   logic [ID_W-1:0]       grant_id;
   logic                  busy;
   logic [CNT_W-1:0]      done_cnt;

   axi4_wr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W),
      .CNT_W   (CNT_W)
   ) dut (
      .m_aclk    (m_aclk),
      .m_arst_n  (m_arst_n),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .grant_id  (grant_id),
      .busy      (busy),
      .done_cnt  (done_cnt)
   );

   initial m_aclk = 1'b0;
   always #5 m_aclk = ~m_aclk;

   typedef struct {
      logic [3:0] add;
      int         win;
      int         dly;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } sb_t;

   vec_t        tbl[12];
   sb_t         sb[$];
   logic [31:0] cur_addr[NUM_REQ];
   logic [31:0] cur_data[NUM_REQ];
   logic [3:0]  pending;
   logic [15:0] exp_done;
   int          n_checks;
   int          n_fail;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_bus();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_addr[32*i +: 32] = cur_addr[i];
         req_data[32*i +: 32] = cur_data[i];
      end
      req_valid = pending;
   endtask

   task automatic push_exp(input int win);
      sb_t e;
      e.addr = cur_addr[win];
      e.data = cur_data[win];
      sb.push_back(e);
   endtask

   // Entered one time unit after an edge with the arbiter idle; returns likewise after completion.
   task automatic do_write(input int win, input int dly);
      sb_t        e;
      logic [3:0] oh;
      oh = 4'b0001 << win;
      @(posedge m_aclk); #1;
      check("grant_ready", 64'(req_ready), 64'(oh));
      check("grant_valid", 64'(wr_valid), 64'd1);
      check("grant_busy", 64'(busy), 64'd1);
      check("grant_id", 64'(grant_id), 64'(win));
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL sb_underflow: got empty queue, expected an entry at %0t", $time);
         e.addr = 'x;
         e.data = 'x;
      end else begin
         e = sb.pop_front();
      end
      check("grant_addr", 64'(wr_addr), 64'(e.addr));
      check("grant_data", 64'(wr_data), 64'(e.data));
      for (int c = 0; c <= dly; c++) begin
         wr_ready = (c == dly);
         @(posedge m_aclk); #1;
         if (c == 0) begin
            pending[win]  = 1'b0;
            cur_addr[win] = $urandom;
            cur_data[win] = $urandom;
            drive_bus();
         end
         if (c < dly) begin
            check("hold_valid", 64'(wr_valid), 64'd1);
            check("hold_ready", 64'(req_ready), 64'd0);
            check("hold_addr", 64'(wr_addr), 64'(e.addr));
            check("hold_data", 64'(wr_data), 64'(e.data));
         end
      end
      wr_ready = 1'b0;
      exp_done++;
      check("done_valid", 64'(wr_valid), 64'd0);
      check("done_busy", 64'(busy), 64'd0);
      check("done_ready", 64'(req_ready), 64'd0);
      check("done_cnt", 64'(done_cnt), 64'(exp_done));
      check("done_grant_id", 64'(grant_id), 64'(win));
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_valid"}, 64'(wr_valid), 64'd0);
      check({name, "_addr"}, 64'(wr_addr), 64'd0);
      check({name, "_data"}, 64'(wr_data), 64'd0);
      check({name, "_ready"}, 64'(req_ready), 64'd0);
      check({name, "_id"}, 64'(grant_id), 64'd0);
      check({name, "_busy"}, 64'(busy), 64'd0);
      check({name, "_cnt"}, 64'(done_cnt), 64'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_done = '0;
      pending  = '0;
      wr_ready = 1'b0;
      m_arst_n = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cur_addr[i] = 32'h2000_0000 + 32'(i * 16);
         cur_data[i] = $urandom;
      end
      cur_addr[2] = 32'h1000_0008;
      cur_data[2] = 32'hDEAD_BEEF;
      drive_bus();

      // Expected winners follow from ptr history starting at 0 and the pending set.
      tbl[0]  = '{4'b0100, 2, 4};
      tbl[1]  = '{4'b1111, 3, 0};
      tbl[2]  = '{4'b0000, 0, 2};
      tbl[3]  = '{4'b0000, 1, 1};
      tbl[4]  = '{4'b1000, 2, 3};
      tbl[5]  = '{4'b0010, 3, 0};
      tbl[6]  = '{4'b0001, 0, 5};
      tbl[7]  = '{4'b0000, 1, 2};
      tbl[8]  = '{4'b0001, 0, 0};
      tbl[9]  = '{4'b0001, 0, 1};
      tbl[10] = '{4'b1001, 3, 2};
      tbl[11] = '{4'b0000, 0, 3};

      #1;
      check_all_zero("reset");
      repeat (2) @(posedge m_aclk);
      @(negedge m_aclk) m_arst_n = 1'b1;
      @(posedge m_aclk); #1;
      check_all_zero("post_reset");

      for (int v = 0; v < 12; v++) begin
         pending = pending | tbl[v].add;
         drive_bus();
         push_exp(tbl[v].win);
         do_write(tbl[v].win, tbl[v].dly);
      end

      // Spurious completion while idle.
      wr_ready = 1'b1;
      @(posedge m_aclk); #1;
      wr_ready = 1'b0;
      @(posedge m_aclk); #1;
      check("spur_valid", 64'(wr_valid), 64'd0);
      check("spur_busy", 64'(busy), 64'd0);
      check("spur_cnt", 64'(done_cnt), 64'(exp_done));

      // Reset while a write is outstanding; ptr is 1 here so requester 1 wins.
      pending = 4'b0010;
      drive_bus();
      @(posedge m_aclk); #1;
      check("rst_busy_pre_valid", 64'(wr_valid), 64'd1);
      check("rst_busy_pre_id", 64'(grant_id), 64'd1);
      @(posedge m_aclk); #1;
      m_arst_n = 1'b0;
      #1;
      check_all_zero("rst_busy");
      exp_done = '0;
      pending  = '0;
      drive_bus();
      @(negedge m_aclk) m_arst_n = 1'b1;
      @(posedge m_aclk); #1;

      // All requesters at once after reset: strict 0,1,2,3 rotation.
      pending = 4'b1111;
      drive_bus();
      for (int i = 0; i < NUM_REQ; i++) push_exp(i);
      for (int i = 0; i < NUM_REQ; i++) do_write(i, 1);
      check("rr_done_cnt", 64'(done_cnt), 64'd4);

      // Counter wrap from 0xFFFF.
      @(negedge m_aclk) force dut.done_cnt_q = 16'hFFFF;
      @(posedge m_aclk); #1;
      release dut.done_cnt_q;
      @(posedge m_aclk); #1;
      check("wrap_pre", 64'(done_cnt), 64'hFFFF);
      exp_done = 16'hFFFF;
      pending  = 4'b0100;
      drive_bus();
      push_exp(2);
      do_write(2, 1);
      check("wrap_zero", 64'(done_cnt), 64'd0);

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
